// File: rtl/csa_acc_pkg.sv
// Shared constants and FSM state encoding for the carry-save packet accumulator.
package csa_acc_pkg;

    localparam int unsigned WORD_W_DEF  = 64;
    localparam int unsigned ACC_W_DEF   = 72;
    localparam int unsigned CHUNK_W_DEF = 24;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcc     = 2'd1,
        StResolve = 2'd2,
        StOut     = 2'd3
    } acc_state_e;

endpackage

// File: rtl/csa_accumulator_row.sv
// Purely combinational 3:2 compressor row: folds one addend into a sum/carry pair.
module csa_row #(
    parameter int unsigned W = 72
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_maj;

    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_sum   = i_a ^ i_b ^ i_c;
    // Top majority bit falls off: the result is defined modulo 2^W.
    assign o_carry = {w_maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Packet accumulator: carry-save per beat, then a chunked ripple resolve before output.
// Define CSA_ACC_OVF_CHECK_EN to enable the beat-count overflow flag on out_ovf.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned WORD_W  = WORD_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned CHUNK_W = CHUNK_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int unsigned NCHUNK = ACC_W / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    acc_state_e       r_state;
    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] r_carry;
    logic [ACC_W-1:0] r_out_data;
    logic             r_cin;
    logic [IDX_W-1:0] r_idx;

    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_row_sum;
    logic [ACC_W-1:0] w_row_carry;
    logic [CHUNK_W:0] w_chunk;
    logic             w_accept;
    logic             w_resolve_done;
    logic             w_release;

    assign in_ready       = (r_state == StIdle) || (r_state == StAcc);
    assign w_accept       = in_valid && in_ready;
    assign w_resolve_done = (r_state == StResolve) && (r_idx == IDX_LAST);
    assign w_release      = (r_state == StOut) && out_ready;
    assign out_valid      = (r_state == StOut);
    assign out_data       = r_out_data;
    assign w_x            = {{(ACC_W - WORD_W){1'b0}}, in_data};

    csa_row #(
        .W (ACC_W)
    ) u_row (
        .i_a     (r_sum),
        .i_b     (r_carry),
        .i_c     (w_x),
        .o_sum   (w_row_sum),
        .o_carry (w_row_carry)
    );

    // One chunk of the final carry-propagate add per cycle, LSB chunk first.
    assign w_chunk = {1'b0, r_sum[r_idx*CHUNK_W +: CHUNK_W]}
                   + {1'b0, r_carry[r_idx*CHUNK_W +: CHUNK_W]}
                   + {{CHUNK_W{1'b0}}, r_cin};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_sum      <= '0;
            r_carry    <= '0;
            r_out_data <= '0;
            r_cin      <= 1'b0;
            r_idx      <= '0;
        end else begin
            unique case (r_state)
                StIdle, StAcc: begin
                    if (w_accept) begin
                        r_sum   <= w_row_sum;
                        r_carry <= w_row_carry;
                        r_cin   <= 1'b0;
                        r_idx   <= '0;
                        r_state <= in_last ? StResolve : StAcc;
                    end
                end
                StResolve: begin
                    r_out_data[r_idx*CHUNK_W +: CHUNK_W] <= w_chunk[CHUNK_W-1:0];
                    r_cin <= w_chunk[CHUNK_W];
                    if (w_resolve_done) begin
                        r_idx   <= '0;
                        r_state <= StOut;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef CSA_ACC_OVF_CHECK_EN
    localparam int unsigned CNT_W = ACC_W - WORD_W + 1;
    // Saturates one past the largest beat count that cannot wrap the accumulator.
    localparam logic [CNT_W-1:0] CNT_MAX = (CNT_W'(1) << (CNT_W - 1)) + CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_resolve_done) begin
                r_ovf <= (r_cnt == CNT_MAX);
            end
            if (w_release) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_ovf = r_ovf;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator; overflow cases run when CSA_ACC_OVF_CHECK_EN is defined.
module tb_csa_accumulator;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned ACC_W  = 72;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             ovf;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    csa_accumulator #(
        .WORD_W  (64),
        .ACC_W   (72),
        .CHUNK_W (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every result that is handed over is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%0h, expected no output", out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_data", out_data, e.data);
                check("result_ovf", ACC_W'(out_ovf), ACC_W'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [ACC_W-1:0] d, input logic ovf);
        exp_t e;
        e.data = d;
        e.ovf  = ovf;
        sb_q.push_back(e);
    endtask

    task automatic beat(input logic [WORD_W-1:0] d, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 40) begin
            tick();
            guard++;
        end
        check(name, ACC_W'(sb_q.size()), '0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset held two cycles
        tick();
        tick();
        check("rst_out_valid", ACC_W'(out_valid), '0);
        check("rst_out_ovf", ACC_W'(out_ovf), '0);
        check("rst_in_ready", ACC_W'(in_ready), 72'd1);
        check("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        tick();

        // Single-beat packet and result latency
        expect_result(72'h5, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'h5;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("lat_t0_in_ready", ACC_W'(in_ready), '0);
        check("lat_t0_valid", ACC_W'(out_valid), '0);
        tick();
        check("lat_t1_valid", ACC_W'(out_valid), '0);
        check("lat_t1_in_ready", ACC_W'(in_ready), '0);
        tick();
        check("lat_t2_valid", ACC_W'(out_valid), '0);
        tick();
        check("lat_t3_valid", ACC_W'(out_valid), 72'd1);
        drain("single_drain");
        check("single_in_ready_back", ACC_W'(in_ready), 72'd1);

        // Carry through every chunk boundary
        expect_result(72'h2_FFFF_FFFF_FFFF_FFFD, 1'b0);
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        drain("ones3_drain");

        // Backpressure: result held, input ignored
        out_ready = 1'b0;
        expect_result(72'h1235, 1'b0);
        beat(64'h1234, 1'b0);
        beat(64'h1, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        check("bp_valid", ACC_W'(out_valid), 72'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 64'hDEAD_BEEF;
            in_last  = 1'b1;
            tick();
            check("bp_hold_data", out_data, 72'h1235);
            check("bp_hold_ovf", ACC_W'(out_ovf), '0);
            check("bp_in_ready", ACC_W'(in_ready), '0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_in_ready_back", ACC_W'(in_ready), 72'd1);
        expect_result(72'h7, 1'b0);
        beat(64'h7, 1'b1);
        drain("bp_next_drain");

        // Reset during RESOLVE abandons the packet
        beat(64'h99, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", ACC_W'(out_valid), '0);
        check("midrst_in_ready", ACC_W'(in_ready), 72'd1);
        check("midrst_data", out_data, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_quiet", ACC_W'(out_valid), '0);
        end
        expect_result(72'h30, 1'b0);
        beat(64'h10, 1'b0);
        beat(64'h20, 1'b1);
        drain("midrst_next_drain");

`ifdef CSA_ACC_OVF_CHECK_EN
        expect_result(72'hFF_FFFF_FFFF_FFFF_FF00, 1'b0);
        for (int i = 0; i < 256; i++) beat(64'hFFFF_FFFF_FFFF_FFFF, i == 255);
        drain("ovf256_drain");
        expect_result(72'h00_FFFF_FFFF_FFFF_FEFF, 1'b1);
        for (int i = 0; i < 257; i++) beat(64'hFFFF_FFFF_FFFF_FFFF, i == 256);
        drain("ovf257_drain");
`endif

        tick();
        check("sb_empty", ACC_W'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL have parameter WORD_W, default 64: input word width.
REQ-002 SHALL have parameter ACC_W, default 72: accumulator and result width; ACC_W > WORD_W.
REQ-003 SHALL have parameter CHUNK_W, default 24: carry-resolve chunk width; ACC_W SHALL be a multiple of CHUNK_W; NCHUNK = ACC_W/CHUNK_W.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: input word offered.
REQ-007 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-008 SHALL have port in_data, input, WORD_W: unsigned word, zero-extended to ACC_W.
REQ-009 SHALL have port in_last, input, 1: qualifies the final word of a packet.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port out_data, output, ACC_W: packet sum modulo 2^ACC_W.
REQ-013 SHALL have port out_ovf, output, 1: word-count overflow flag (see Configuration).

Function
REQ-014 SHALL implement the FSM states IDLE, ACC, RESOLVE and OUT.
REQ-015 SHALL drive in_ready=1 in IDLE/ACC and 0 in RESOLVE/OUT; in_valid while in_ready=0 is ignored.
REQ-016 SHALL, on each accepted beat, update redundant state with one 3:2 row: sum'=sum^carry^x; carry'=(maj(sum,carry,x)<<1), truncated to ACC_W.
REQ-017 SHALL transition IDLE->ACC on an accepted non-last beat, and IDLE/ACC->RESOLVE on an accepted beat with in_last=1; a single-beat packet is legal.
REQ-018 SHALL, in RESOLVE, process chunk k=0..NCHUNK-1 one per cycle, LSB first: res[k]=sum[k]+carry[k]+cin; cin is registered between chunks, starts at 0, and the top carry-out is discarded.
REQ-019 SHALL enter OUT after exactly NCHUNK RESOLVE cycles; for a last beat accepted at edge T, out_valid SHALL rise after edge T+NCHUNK (default: 3 cycles in RESOLVE).
REQ-020 SHALL hold out_data and out_ovf stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on out_valid&out_ready, return to IDLE, clear sum/carry/count, and reassert in_ready on the next cycle; the result path has no bypass.
REQ-022 SHALL NOT change the FSM while in IDLE with in_valid=0.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, set state=IDLE, sum=0, carry=0, cin=0, chunk index=0, out_data=0, out_valid=0 and out_ovf=0; in_ready SHALL be 1 after the edge.
REQ-024 SHALL abandon any in-progress packet on reset in ACC, RESOLVE or OUT; no partial result SHALL be emitted.

Configuration
REQ-025 SHALL support macro CSA_ACC_OVF_CHECK_EN; when defined, a beat counter saturating at 2^(ACC_W-WORD_W)+1 SHALL set out_ovf=1 with the result when the packet held more than 2^(ACC_W-WORD_W) beats.
REQ-026 SHALL, when CSA_ACC_OVF_CHECK_EN is undefined, omit the counter and tie out_ovf to 0.

Structure
REQ-027 SHALL take the FSM state enum and the default WORD_W/ACC_W/CHUNK_W constants from shared package csa_acc_pkg.
REQ-028 SHALL implement the 3:2 row as sub-module csa_row (ACC_W-wide, purely combinational); the FSM, registers and chunked adder SHALL reside in csa_accumulator.

Verification (defaults; NCHUNK=3)
REQ-029 SHALL cover reset: hold rst_n=0 two cycles -> out_valid=0, out_ovf=0, in_ready=1, out_data=0.
REQ-030 SHALL cover a single beat 0x5 with in_last at edge T -> out_valid rises after edge T+3, out_data=0x5, in_ready=0 during RESOLVE.
REQ-031 SHALL cover three beats of 0xFFFF_FFFF_FFFF_FFFF -> out_data=0x2_FFFF_FFFF_FFFF_FFFD; this exercises the carry across all chunk boundaries.
REQ-032 SHALL cover backpressure: out_ready=0 for 10 cycles -> out_data/out_ovf stable, in_ready=0, in_valid beats ignored; on release, in_ready=1 on the following cycle.
REQ-033 SHALL cover overflow with the macro defined: 256 all-ones beats -> out_ovf=0; 257 beats -> out_ovf=1, and out_data=257*(2^64-1) mod 2^72.
REQ-034 SHALL cover reset mid-RESOLVE -> IDLE, no out_valid; the next packet {0x10, 0x20 last} -> out_data=0x30.
